// File: rtl/uart_rx_os16.sv
// rtl/uart_rx_os16.sv - 8N1/8E1/8O1 UART receiver, OSR-times oversampled with mid-bit majority vote
module uart_rx_os16 #(
  parameter int OSR         = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       baud_clk,
  input  logic       rst_n,
  input  logic       rx_en,
  input  logic       n_parity,
  input  logic       ev_parity,
  input  logic       RXD,
  output logic [7:0] rxd_out,
  output logic       rx_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int CW = $clog2(OSR);
  localparam logic [CW-1:0] OS_SMP0 = CW'(OSR / 2 - 1);
  localparam logic [CW-1:0] OS_SMP1 = CW'(OSR / 2);
  localparam logic [CW-1:0] OS_RES  = CW'(OSR / 2 + 1);
  localparam logic [CW-1:0] OS_LAST = CW'(OSR - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   rxs_prev_q, rxs_prev_d;
  logic [2:0]             state_q, state_d;
  logic [CW-1:0]          os_cnt_q, os_cnt_d;
  logic [3:0]             bit_cnt_q, bit_cnt_d;
  logic                   smp0_q, smp0_d, smp1_q, smp1_d;
  logic [7:0]             shreg_q, shreg_d;
  logic                   cfg_npar_q, cfg_npar_d, cfg_even_q, cfg_even_d;
  logic                   par_pend_q, par_pend_d;
  logic                   armed_q, armed_d;
  logic [7:0]             rxd_out_q, rxd_out_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   parity_err_q, parity_err_d;
  logic                   frame_err_q, frame_err_d;

  logic rxs, vote, at_res, at_last, exp_par;

  assign rxs     = sync_q[SYNC_STAGES-1];
  assign vote    = (smp0_q & smp1_q) | (smp0_q & rxs) | (smp1_q & rxs);
  assign at_res  = (os_cnt_q == OS_RES);
  assign at_last = (os_cnt_q == OS_LAST);
  assign exp_par = cfg_even_q ? ^shreg_q : ~^shreg_q;

  assign rxd_out    = rxd_out_q;
  assign rx_valid   = rx_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign rx_busy    = (state_q != S_IDLE);

  // Next-state logic: synchronizer, bit timing, vote, frame FSM and output capture
  always_comb begin
    sync_d       = {sync_q[SYNC_STAGES-2:0], RXD};
    rxs_prev_d   = rxs;
    state_d      = state_q;
    os_cnt_d     = at_last ? '0 : os_cnt_q + CW'(1);
    bit_cnt_d    = bit_cnt_q;
    smp0_d       = (os_cnt_q == OS_SMP0) ? rxs : smp0_q;
    smp1_d       = (os_cnt_q == OS_SMP1) ? rxs : smp1_q;
    shreg_d      = shreg_q;
    cfg_npar_d   = cfg_npar_q;
    cfg_even_d   = cfg_even_q;
    par_pend_d   = par_pend_q;
    armed_d      = armed_q;
    rxd_out_d    = rxd_out_q;
    rx_valid_d   = 1'b0;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;

    // A high line in IDLE re-arms detection after a framing error (break).
    if (state_q == S_IDLE && rxs) armed_d = 1'b1;

    if (!rx_en) begin
      state_d   = S_IDLE;
      os_cnt_d  = '0;
      bit_cnt_d = 4'd0;
      shreg_d   = 8'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          os_cnt_d = '0;
          if (!rxs && rxs_prev_q && armed_q) begin
            state_d    = S_START;
            bit_cnt_d  = 4'd0;
            cfg_npar_d = n_parity;
            cfg_even_d = ev_parity;
            par_pend_d = 1'b0;
          end
        end
        S_START: begin
          if (at_res && vote) begin
            state_d  = S_IDLE;
            os_cnt_d = '0;
          end else if (at_last) begin
            state_d   = S_DATA;
            bit_cnt_d = 4'd0;
          end
        end
        S_DATA: begin
          if (at_res) shreg_d = {vote, shreg_q[7:1]};
          if (at_last) begin
            if (bit_cnt_q == 4'd7) begin
              state_d   = cfg_npar_q ? S_STOP : S_PARITY;
              bit_cnt_d = 4'd0;
            end else begin
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end
        S_PARITY: begin
          if (at_res && (vote != exp_par)) par_pend_d = 1'b1;
          if (at_last) state_d = S_STOP;
        end
        S_STOP: begin
          if (at_res) begin
            rxd_out_d    = shreg_q;
            parity_err_d = ~cfg_npar_q & par_pend_q;
            frame_err_d  = ~vote;
            rx_valid_d   = 1'b1;
            state_d      = S_IDLE;
            os_cnt_d     = '0;
            if (!vote) armed_d = 1'b0;
          end
        end
        default: begin
          state_d  = S_IDLE;
          os_cnt_d = '0;
        end
      endcase
    end
  end

  // State registers; the synchronizer resets to the idle (high) line level
  always_ff @(posedge baud_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q       <= '1;
      rxs_prev_q   <= 1'b1;
      state_q      <= S_IDLE;
      os_cnt_q     <= '0;
      bit_cnt_q    <= 4'd0;
      smp0_q       <= 1'b1;
      smp1_q       <= 1'b1;
      shreg_q      <= 8'd0;
      cfg_npar_q   <= 1'b0;
      cfg_even_q   <= 1'b0;
      par_pend_q   <= 1'b0;
      armed_q      <= 1'b1;
      rxd_out_q    <= 8'd0;
      rx_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      rxs_prev_q   <= rxs_prev_d;
      state_q      <= state_d;
      os_cnt_q     <= os_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      smp0_q       <= smp0_d;
      smp1_q       <= smp1_d;
      shreg_q      <= shreg_d;
      cfg_npar_q   <= cfg_npar_d;
      cfg_even_q   <= cfg_even_d;
      par_pend_q   <= par_pend_d;
      armed_q      <= armed_d;
      rxd_out_q    <= rxd_out_d;
      rx_valid_q   <= rx_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
    end
  end

endmodule
